// File: rtl/led_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_frame_sequencer
// Brief    : Walks the LED chain once per refresh, fetching each pixel and
//            handing it to the serial driver; slots buffer commits between frames.
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_sequencer #(
    parameter int NUM_LEDS      = 140,
    parameter int LEDS_PER_CHAR = 35,
    parameter int NUM_CHARS     = 4
) (
    input  logic        clk20,
    input  logic        reset,
    input  logic        refresh,
    input  logic        commit_req,
    output logic        commit_gnt,
    output logic        pix_req,
    output logic [1:0]  pix_slot,
    output logic [5:0]  pix_bit,
    input  logic        pix_ack,
    input  logic [23:0] pix_data,
    output logic [23:0] drv_data,
    output logic        drv_valid,
    output logic        drv_latch,
    input  logic        drv_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  skip_count
);

    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_FETCH        = 2'd1;
    localparam logic [1:0] c_WAIT_READY   = 2'd2;
    localparam logic [1:0] c_WAIT_STARTED = 2'd3;

    localparam logic [7:0] c_LAST_LED  = 8'(NUM_LEDS - 1);
    localparam logic [5:0] c_LAST_BIT  = 6'(LEDS_PER_CHAR - 1);
    localparam logic [1:0] c_LAST_SLOT = 2'(NUM_CHARS - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_led_index;
    logic [1:0]  r_slot;
    logic [5:0]  r_bit;
    logic [23:0] r_drv_data;
    logic        r_drv_valid;
    logic        r_drv_latch;
    logic        r_commit_gnt;
    logic        r_frame_done;
    logic [7:0]  r_skip_count;

    logic        w_idle;
    logic        w_refresh_drop;
    logic        w_last_pixel;

    assign w_idle         = (r_state == c_IDLE);
    // A refresh only starts a frame from IDLE with no competing commit.
    assign w_refresh_drop = refresh && (!w_idle || commit_req);
    assign w_last_pixel   = (r_led_index == c_LAST_LED);

    always_ff @(posedge clk20) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_led_index  <= 8'd0;
            r_slot       <= 2'd0;
            r_bit        <= 6'd0;
            r_drv_data   <= 24'd0;
            r_drv_valid  <= 1'b0;
            r_drv_latch  <= 1'b0;
            r_commit_gnt <= 1'b0;
            r_frame_done <= 1'b0;
            r_skip_count <= 8'd0;
        end else begin
            r_commit_gnt <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_refresh_drop && (r_skip_count != 8'hFF)) begin
                r_skip_count <= r_skip_count + 8'd1;
            end

            case (r_state)
                c_IDLE: begin
                    // The writer still holds its request during the grant cycle,
                    // so a fresh grant waits until the previous one has ended.
                    if (commit_req) begin
                        r_commit_gnt <= !r_commit_gnt;
                    end else if (refresh) begin
                        r_led_index <= 8'd0;
                        r_slot      <= 2'd0;
                        r_bit       <= 6'd0;
                        r_state     <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (pix_ack) begin
                        r_drv_data <= pix_data;
                        r_state    <= c_WAIT_READY;
                    end
                end
                c_WAIT_READY: begin
                    if (drv_ready) begin
                        r_drv_valid <= 1'b1;
                        r_drv_latch <= w_last_pixel;
                        r_state     <= c_WAIT_STARTED;
                    end
                end
                c_WAIT_STARTED: begin
                    // The driver drops ready once it has taken the pixel.
                    if (!drv_ready) begin
                        r_drv_valid <= 1'b0;
                        r_drv_latch <= 1'b0;
                        if (w_last_pixel) begin
                            r_led_index  <= 8'd0;
                            r_slot       <= 2'd0;
                            r_bit        <= 6'd0;
                            r_frame_done <= 1'b1;
                            r_state      <= c_IDLE;
                        end else begin
                            r_led_index <= r_led_index + 8'd1;
                            if (r_bit == c_LAST_BIT) begin
                                r_bit  <= 6'd0;
                                r_slot <= (r_slot == c_LAST_SLOT) ? 2'd0 : r_slot + 2'd1;
                            end else begin
                                r_bit <= r_bit + 6'd1;
                            end
                            r_state <= c_FETCH;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign commit_gnt = r_commit_gnt;
    assign pix_req    = (r_state == c_FETCH);
    assign pix_slot   = r_slot;
    assign pix_bit    = r_bit;
    assign drv_data   = r_drv_data;
    assign drv_valid  = r_drv_valid;
    assign drv_latch  = r_drv_latch;
    assign busy       = !w_idle;
    assign frame_done = r_frame_done;
    assign skip_count = r_skip_count;

endmodule
`default_nettype wire

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Frame-level scheduler for the WS2812B character-matrix chain.
- On each refresh pulse it walks the NUM_LEDS pixels in order and fetches each pixel's colour from the glyph/colour lookup logic through a req/ack port.
- It hands each pixel to the serial LED driver with a valid/ready handshake and asserts latch on the last pixel.
- It also arbitrates text/colour buffer commits against frame scans, so a commit never lands mid-frame.

Parameters:
- NUM_LEDS, 140: pixels per frame.
- LEDS_PER_CHAR, 35: pixels per character cell (5x7 glyph).
- NUM_CHARS, 4: character slots; NUM_LEDS = NUM_CHARS*LEDS_PER_CHAR.

Ports:
- clk20  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- refresh  in  1  one-cycle frame start pulse.
- commit_req  in  1  level request from the buffer writer to update text/colour buffers.
- commit_gnt  out  1  one-cycle grant; the writer performs its update in the grant cycle.
- pix_req  out  1  pixel fetch request.
- pix_slot  out  2  character slot of the requested pixel.
- pix_bit  out  6  glyph bit index (0..LEDS_PER_CHAR-1).
- pix_ack  in  1  fetch complete; pix_data valid this cycle.
- pix_data  in  24  GRB colour (already masked by the glyph bit).
- drv_data  out  24  pixel to the driver.
- drv_valid  out  1  driver handshake valid.
- drv_latch  out  1  last-pixel marker, qualified by drv_valid.
- drv_ready  in  1  driver idle/accepting.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.
- skip_count  out  8  saturating count of dropped refresh pulses.

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0: commit_gnt, pix_req, pix_slot, pix_bit, drv_data, drv_valid, drv_latch, busy, frame_done, skip_count. Internal led_index=0. Reset mid-frame aborts immediately; the next frame starts at pixel 0.
- IDLE:
  - If commit_req=1, pulse commit_gnt for one cycle. Commit has priority over refresh in the same cycle; that refresh is dropped and skip_count increments.
  - Otherwise, if refresh=1, go to FETCH next cycle with led_index=0, slot=0, bit=0.
- FETCH:
  - pix_req=1, with pix_slot/pix_bit stable.
  - On the pix_ack cycle, capture pix_data into drv_data and go to WAIT_READY. pix_req is 0 from the next cycle.
  - Ack latency is unbounded. pix_ack outside FETCH is ignored.
- WAIT_READY:
  - When drv_ready=1, assert drv_valid next cycle.
  - drv_latch = (led_index == NUM_LEDS-1).
  - Go to WAIT_STARTED.
- WAIT_STARTED:
  - Hold drv_valid, drv_data and drv_latch until drv_ready=0. The cycle after, drv_valid=0 and drv_latch=0.
  - Advance led_index. bit increments and wraps LEDS_PER_CHAR-1 -> 0, with slot+1 on wrap.
  - If the accepted pixel was the last one, pulse frame_done and return to IDLE. Otherwise go to FETCH.
- Refresh while busy=1 is dropped; skip_count+1, saturating at 255. Dropped refreshes are never queued.
- commit_req while busy is held off. commit_gnt is never asserted while busy=1.
- After frame_done, IDLE is re-entered and commit_req is serviced before any later refresh.
- led_index width: 8 bits; never exceeds NUM_LEDS-1.
- pix_slot width: 2 bits; never exceeds NUM_CHARS-1.

Test Plan:
- Basic frame: model with pix_ack 1 cycle after req, driver dropping ready 2 cycles after valid, holding busy 5 cycles. Pulse refresh -> exactly 140 drv_valid handshakes.
  - Pixel 0 has slot=0, bit=0; pixel 35 has slot=1, bit=0; pixel 139 has slot=3, bit=34.
  - drv_latch=1 only on pixel 139; one frame_done pulse.
- Fetch stall: hold pix_ack low for 50 cycles on pixel 10 -> pix_req stays high and slot/bit stay stable; drv_valid stays low; data order is intact.
- Refresh overrun: pulse refresh 3 times mid-frame -> skip_count=3, no restart, frame completes normally. After 300 extra dropped pulses -> skip_count=255.
- Commit arbitration: commit_req raised at pixel 50 -> commit_gnt stays 0 until frame_done, then pulses exactly once. With commit_req and refresh in the same IDLE cycle -> gnt pulses, frame does not start, skip_count+1.
- Reset mid-frame: reset at pixel 70 -> all outputs 0 next cycle. The next refresh starts at slot=0, bit=0, and skip_count is 0.
- Driver handshake: drv_ready held low 100 cycles in WAIT_READY -> drv_valid stays 0. drv_data is unchanged while drv_valid=1 until ready falls.
